// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the two-requester DDR burst arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: default widths, requester IDs, arbiter FSM state encoding.
package ddr_arb_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_LEN_W  = 3;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker with an internal priority pointer.
// Latency: grant_id/any combinational from i_req; pointer updates on the edge after i_update.
// Backpressure: none; the caller decides when a pick is taken.
// Ports: i_clock, i_reset (sync, active-high); i_req[1:0] (bit0 = A, bit1 = B);
//        i_update + i_last_owner move the pointer to favour the other requester;
//        o_grant_id = winning requester ID, o_any = some request is active.
module rr_arb2
  import ddr_arb_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_last_owner,
  output logic       o_grant_id,
  output logic       o_any
);

  // Requester that wins a tie; starts out favouring A.
  logic r_prio;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_prio <= REQ_A;
    end else if (i_update) begin
      r_prio <= ~i_last_owner;
    end
  end

  always_comb begin
    o_any      = |i_req;
    o_grant_id = REQ_A;
    if (&i_req) begin
      o_grant_id = r_prio;
    end else if (i_req[1]) begin
      o_grant_id = REQ_B;
    end
  end

endmodule

// File: rtl/ddr_burst_arbiter.sv
// Round-robin arbiter + burst sequencer owning a registered-read 2^ADDR_W x DATA_W memory.
// Latency: req before edge N -> gnt/first ack after N; write L+2 cycles, read L+3 cycles to IDLE.
// Backpressure: none; a granted burst runs one beat per cycle, other requests wait in IDLE.
// Ports: i_clock, i_reset (sync, active-high); per requester x in {a,b}:
//        i_x_req/we/addr/len/wdata in, o_x_gnt/ack/rvalid/rdata/done out;
//        o_mem_wr/rd/wr_add/rd_add/data_in, i_mem_data_out to the memory; o_busy = not IDLE.
module ddr_burst_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_a_req,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [LEN_W-1:0]  i_a_len,
  input  logic [DATA_W-1:0] i_a_wdata,
  output logic              o_a_gnt,
  output logic              o_a_ack,
  output logic              o_a_rvalid,
  output logic [DATA_W-1:0] o_a_rdata,
  output logic              o_a_done,
  input  logic              i_b_req,
  input  logic              i_b_we,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [LEN_W-1:0]  i_b_len,
  input  logic [DATA_W-1:0] i_b_wdata,
  output logic              o_b_gnt,
  output logic              o_b_ack,
  output logic              o_b_rvalid,
  output logic [DATA_W-1:0] o_b_rdata,
  output logic              o_b_done,
  output logic              o_mem_wr,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_wr_add,
  output logic [ADDR_W-1:0] o_mem_rd_add,
  output logic [DATA_W-1:0] o_mem_data_in,
  input  logic [DATA_W-1:0] i_mem_data_out,
  output logic              o_busy
);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_a_rvalid;
  logic              r_b_rvalid;
  logic              w_grant_id;
  logic              w_any;
  logic              w_update;
  logic              w_beat;
  logic              w_owns;

  rr_arb2 u_rr_arb2 (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_req        ({i_b_req, i_a_req}),
    .i_update     (w_update),
    .i_last_owner (r_owner),
    .o_grant_id   (w_grant_id),
    .o_any        (w_any)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_beat   = 1'b0;
    w_update = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_next = ST_BURST;
        end
      end
      ST_BURST: begin
        w_beat = 1'b1;
        // r_cnt holds beats remaining minus one; zero marks the final beat.
        if (r_cnt == '0) begin
          w_next = r_we ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_next = ST_DONE;
      end
      ST_DONE: begin
        w_update = 1'b1;
        w_next   = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Burst context is captured only on the IDLE->BURST pick; requester
  // fields are don't-care for the rest of the burst.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_owner    <= REQ_A;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      // Memory read data lands one cycle after the read beat.
      r_a_rvalid <= w_beat & ~r_we & (r_owner == REQ_A);
      r_b_rvalid <= w_beat & ~r_we & (r_owner == REQ_B);
      if ((r_state == ST_IDLE) && w_any) begin
        r_owner <= w_grant_id;
        r_we    <= (w_grant_id == REQ_B) ? i_b_we   : i_a_we;
        r_addr  <= (w_grant_id == REQ_B) ? i_b_addr : i_a_addr;
        r_cnt   <= (w_grant_id == REQ_B) ? i_b_len  : i_a_len;
      end else if (w_beat) begin
        r_addr <= r_addr + ADDR_W'(1);
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - LEN_W'(1);
        end
      end
    end
  end

  assign w_owns = (r_state != ST_IDLE);
  assign o_busy = w_owns;

  assign o_a_gnt  = w_owns & (r_owner == REQ_A);
  assign o_b_gnt  = w_owns & (r_owner == REQ_B);
  assign o_a_ack  = w_beat & (r_owner == REQ_A);
  assign o_b_ack  = w_beat & (r_owner == REQ_B);
  assign o_a_done = (r_state == ST_DONE) & (r_owner == REQ_A);
  assign o_b_done = (r_state == ST_DONE) & (r_owner == REQ_B);

  assign o_mem_wr      = w_beat & r_we;
  assign o_mem_rd      = w_beat & ~r_we;
  assign o_mem_wr_add  = o_mem_wr ? r_addr : '0;
  assign o_mem_rd_add  = o_mem_rd ? r_addr : '0;
  assign o_mem_data_in = o_mem_wr ? ((r_owner == REQ_B) ? i_b_wdata : i_a_wdata) : '0;

  assign o_a_rvalid = r_a_rvalid;
  assign o_b_rvalid = r_b_rvalid;
  assign o_a_rdata  = r_a_rvalid ? i_mem_data_out : '0;
  assign o_b_rdata  = r_b_rvalid ? i_mem_data_out : '0;

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Testbench for ddr_burst_arbiter with a behavioural memory and a burst-schedule model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ddr_burst_arbiter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [2:0] a_addr, a_len, b_addr, b_len;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, a_ack, a_rvalid, a_done;
  logic       b_gnt, b_ack, b_rvalid, b_done;
  logic [7:0] a_rdata, b_rdata;
  logic       mem_wr, mem_rd, busy;
  logic [2:0] mem_wr_add, mem_rd_add;
  logic [7:0] mem_data_in, mem_dout;

  ddr_burst_arbiter dut (
    .i_clock(clk), .i_reset(rst),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_len(a_len), .i_a_wdata(a_wdata),
    .o_a_gnt(a_gnt), .o_a_ack(a_ack), .o_a_rvalid(a_rvalid), .o_a_rdata(a_rdata), .o_a_done(a_done),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_len(b_len), .i_b_wdata(b_wdata),
    .o_b_gnt(b_gnt), .o_b_ack(b_ack), .o_b_rvalid(b_rvalid), .o_b_rdata(b_rdata), .o_b_done(b_done),
    .o_mem_wr(mem_wr), .o_mem_rd(mem_rd), .o_mem_wr_add(mem_wr_add), .o_mem_rd_add(mem_rd_add),
    .o_mem_data_in(mem_data_in), .i_mem_data_out(mem_dout), .o_busy(busy)
  );

  // The memory the arbiter drives: registered read, one-cycle latency.
  logic [7:0] mem [8];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_wr_add] <= mem_data_in;
    if (mem_rd) mem_dout <= mem[mem_rd_add];
  end

  // Expected outputs for one cycle of a granted burst.
  typedef struct {
    bit gnt_a, gnt_b, ack_a, ack_b, mwr, mrd, wbeat, own;
    bit rv_a, rv_b, done_a, done_b, is_done;
    int wadd, radd, rdata;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mm [8];
  bit         ptr;
  int         n_chk = 0, n_fail = 0, cyc = 0;
  int         rd_beats = 0, rv_cnt = 0;
  bit         prev_busy = 1'b0;
  int         wr_add_log[$], wr_dat_log[$], wr_cyc_log[$];
  int         rd_a_log[$], rd_b_log[$], rd_cyc_log[$], rv_cyc_log[$];
  int         gnt_log[$], done_log[$], done_cyc_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Schedule every cycle of a burst from the burst-level rules.
  task automatic gen(input bit own, input bit we, input logic [2:0] addr, input logic [2:0] len);
    int L;
    exp_t e;
    logic [2:0] ad;
    L = int'(len) + 1;
    for (int i = 0; i < L; i++) begin
      e = '{default: 0};
      e.own = own;
      if (own) begin e.gnt_b = 1; e.ack_b = 1; end
      else     begin e.gnt_a = 1; e.ack_a = 1; end
      ad = addr + 3'(i);
      if (we) begin e.mwr = 1; e.wbeat = 1; e.wadd = int'(ad); end
      else    begin e.mrd = 1; e.radd = int'(ad); end
      if (!we && i > 0) begin
        ad = addr + 3'(i - 1);
        if (own) e.rv_b = 1; else e.rv_a = 1;
        e.rdata = int'(mm[ad]);
      end
      q.push_back(e);
    end
    if (!we) begin
      e = '{default: 0};
      e.own = own;
      if (own) begin e.gnt_b = 1; e.rv_b = 1; end
      else     begin e.gnt_a = 1; e.rv_a = 1; end
      ad = addr + 3'(L - 1);
      e.rdata = int'(mm[ad]);
      q.push_back(e);
    end
    e = '{default: 0};
    e.own = own;
    e.is_done = 1;
    if (own) begin e.gnt_b = 1; e.done_b = 1; end
    else     begin e.gnt_a = 1; e.done_a = 1; end
    q.push_back(e);
  endtask

  // One clock: compare at negedge, advance the model at posedge, drive at posedge+1.
  task automatic step();
    exp_t e;
    bit   idle, aa, ba;
    logic [7:0] wd;
    @(negedge clk);
    cyc++;
    idle = (q.size() == 0);
    if (idle) e = '{default: 0};
    else      e = q[0];
    wd = e.wbeat ? (e.own ? b_wdata : a_wdata) : 8'h00;
    chk("busy",     32'(busy),        32'(!idle));
    chk("a_gnt",    32'(a_gnt),       32'(e.gnt_a));
    chk("b_gnt",    32'(b_gnt),       32'(e.gnt_b));
    chk("a_ack",    32'(a_ack),       32'(e.ack_a));
    chk("b_ack",    32'(b_ack),       32'(e.ack_b));
    chk("mem_wr",   32'(mem_wr),      32'(e.mwr));
    chk("mem_rd",   32'(mem_rd),      32'(e.mrd));
    chk("wr_add",   32'(mem_wr_add),  32'(e.wadd));
    chk("rd_add",   32'(mem_rd_add),  32'(e.radd));
    chk("data_in",  32'(mem_data_in), 32'(wd));
    chk("a_rvalid", 32'(a_rvalid),    32'(e.rv_a));
    chk("b_rvalid", 32'(b_rvalid),    32'(e.rv_b));
    chk("a_rdata",  32'(a_rdata),     e.rv_a ? e.rdata : 0);
    chk("b_rdata",  32'(b_rdata),     e.rv_b ? e.rdata : 0);
    chk("a_done",   32'(a_done),      32'(e.done_a));
    chk("b_done",   32'(b_done),      32'(e.done_b));
    chk("wr_rd_excl", 32'(mem_wr & mem_rd), 0);
    chk("gnt_onehot", 32'(a_gnt & b_gnt),   0);
    if (mem_wr) begin
      wr_add_log.push_back(int'(mem_wr_add));
      wr_dat_log.push_back(int'(mem_data_in));
      wr_cyc_log.push_back(cyc);
    end
    if (mem_rd) begin rd_beats++; rd_cyc_log.push_back(cyc); end
    if (a_rvalid) begin rv_cnt++; rd_a_log.push_back(int'(a_rdata)); rv_cyc_log.push_back(cyc); end
    if (b_rvalid) begin rv_cnt++; rd_b_log.push_back(int'(b_rdata)); rv_cyc_log.push_back(cyc); end
    if (busy && !prev_busy) gnt_log.push_back(int'(b_gnt));
    if (a_done || b_done) begin done_log.push_back(int'(b_done)); done_cyc_log.push_back(cyc); end
    prev_busy = busy;
    aa = a_ack;
    ba = b_ack;
    @(posedge clk);
    if (q.size() == 0) begin
      if (!rst && (a_req || b_req)) begin
        if (a_req && b_req) begin
          if (ptr) gen(1'b1, b_we, b_addr, b_len);
          else     gen(1'b0, a_we, a_addr, a_len);
        end else if (b_req) gen(1'b1, b_we, b_addr, b_len);
        else                gen(1'b0, a_we, a_addr, a_len);
      end
    end else begin
      e = q.pop_front();
      if (e.wbeat) mm[3'(e.wadd)] = e.own ? b_wdata : a_wdata;
      if (e.is_done) ptr = !e.own;
    end
    if (rst) begin
      q.delete();
      ptr = 1'b0;
    end
    #1;
    if (aa) a_wdata = a_wdata + 8'd1;
    if (ba) b_wdata = b_wdata + 8'd1;
  endtask

  task automatic burst(input bit who, input bit we, input logic [2:0] addr,
                       input logic [2:0] len, input logic [7:0] d);
    int n;
    if (who) begin b_req = 1; b_we = we; b_addr = addr; b_len = len; b_wdata = d; end
    else     begin a_req = 1; a_we = we; a_addr = addr; a_len = len; a_wdata = d; end
    n = 0;
    while (!(who ? b_gnt : a_gnt) && n < 30) begin step(); n++; end
    chk("grant_timeout", 32'(n < 30), 1);
    a_req = 0;
    b_req = 0;
    n = 0;
    while (busy && n < 30) begin step(); n++; end
    chk("idle_timeout", 32'(n < 30), 1);
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin
    int s, r, g, d, n, rb, rv;
    int exp_w[4];
    int exp_g[4];
    rst = 1; a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    a_addr = 0; b_addr = 0; a_len = 0; b_len = 0; a_wdata = 0; b_wdata = 0;
    ptr = 0;
    step(); step();
    chk("rst_busy",   32'(busy), 0);
    chk("rst_gnt",    32'({a_gnt, b_gnt}), 0);
    chk("rst_mem",    32'({mem_wr, mem_rd, mem_wr_add, mem_rd_add, mem_data_in}), 0);
    chk("rst_rvalid", 32'({a_rvalid, b_rvalid, a_done, b_done}), 0);
    rst = 0;

    // Fill the whole memory with E0..E7.
    burst(1'b0, 1'b1, 3'd0, 3'd7, 8'hE0);
    chk("init_last_data", wr_dat_log[wr_dat_log.size()-1], 32'hE7);

    // Single write then readback.
    s = wr_add_log.size(); d = done_cyc_log.size();
    burst(1'b0, 1'b1, 3'd2, 3'd0, 8'h5A);
    chk("sw_count", wr_add_log.size() - s, 1);
    chk("sw_add",   wr_add_log[s], 2);
    chk("sw_data",  wr_dat_log[s], 32'h5A);
    chk("sw_done_lat", done_cyc_log[d] - wr_cyc_log[s], 1);
    r = rd_a_log.size(); s = rd_cyc_log.size(); g = rv_cyc_log.size();
    burst(1'b0, 1'b0, 3'd2, 3'd0, 8'h00);
    chk("rb_count", rd_a_log.size() - r, 1);
    chk("rb_data",  rd_a_log[r], 32'h5A);
    chk("rb_lat",   rv_cyc_log[g] - rd_cyc_log[s], 1);

    // Wrap-around write by B, read back by A.
    s = wr_add_log.size();
    burst(1'b1, 1'b1, 3'd6, 3'd3, 8'h10);
    exp_w = '{6, 7, 0, 1};
    chk("wrap_count", wr_add_log.size() - s, 4);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_add",  wr_add_log[s+i], exp_w[i]);
      chk("wrap_data", wr_dat_log[s+i], 32'h10 + i);
    end
    r = rd_a_log.size();
    burst(1'b0, 1'b0, 3'd6, 3'd3, 8'h00);
    chk("wrap_rd_count", rd_a_log.size() - r, 4);
    for (int i = 0; i < 4; i++) chk("wrap_rd_data", rd_a_log[r+i], 32'h10 + i);

    // Both held after reset: grants alternate starting with A.
    do_reset();
    g = gnt_log.size(); d = done_log.size();
    a_req = 1; a_we = 0; a_addr = 3'd0; a_len = 3'd1;
    b_req = 1; b_we = 1; b_addr = 3'd4; b_len = 3'd0; b_wdata = 8'h30;
    n = 0;
    while (done_log.size() - d < 4 && n < 100) begin step(); n++; end
    chk("fair_timeout", 32'(n < 100), 1);
    a_req = 0; b_req = 0;
    n = 0;
    while (busy && n < 30) begin step(); n++; end
    exp_g = '{0, 1, 0, 1};
    chk("fair_bursts", gnt_log.size() - g, 4);
    for (int i = 0; i < 4; i++) begin
      chk("fair_gnt",  gnt_log[g+i],  exp_g[i]);
      chk("fair_done", done_log[d+i], exp_g[i]);
    end

    // After a lone B burst, a tie goes to A.
    do_reset();
    burst(1'b1, 1'b0, 3'd0, 3'd0, 8'h00);
    g = gnt_log.size(); d = done_log.size();
    a_req = 1; b_req = 1; a_we = 0; b_we = 0;
    n = 0;
    while (done_log.size() - d < 2 && n < 50) begin step(); n++; end
    a_req = 0; b_req = 0;
    n = 0;
    while (busy && n < 30) begin step(); n++; end
    chk("tie_first",  gnt_log[g],   0);
    chk("tie_second", gnt_log[g+1], 1);

    // Reset during beat 3 of an 8-beat write.
    a_req = 1; a_we = 1; a_addr = 3'd0; a_len = 3'd7; a_wdata = 8'h80;
    n = 0;
    while (!a_gnt && n < 30) begin step(); n++; end
    a_req = 0;
    step();
    step();
    rst = 1;
    d = done_log.size();
    step();
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_outs", 32'({a_gnt, a_ack, a_done, mem_wr, mem_rd, a_rvalid, mem_data_in}), 0);
    rst = 0;
    for (int i = 0; i < 5; i++) step();
    chk("mid_rst_no_done", done_log.size() - d, 0);
    g = gnt_log.size(); r = rd_a_log.size();
    burst(1'b0, 1'b0, 3'd0, 3'd2, 8'h00);
    chk("post_rst_gnt", gnt_log[g], 0);
    for (int i = 0; i < 3; i++) chk("post_rst_data", rd_a_log[r+i], 32'h80 + i);

    // Random traffic.
    rb = rd_beats; rv = rv_cnt;
    for (int i = 0; i < 2000; i++) begin
      a_req = ($urandom_range(0, 3) != 0); a_we = 1'($urandom_range(0, 1));
      a_addr = 3'($urandom_range(0, 7));   a_len = 3'($urandom_range(0, 7));
      a_wdata = 8'($urandom);
      b_req = ($urandom_range(0, 3) != 0); b_we = 1'($urandom_range(0, 1));
      b_addr = 3'($urandom_range(0, 7));   b_len = 3'($urandom_range(0, 7));
      b_wdata = 8'($urandom);
      step();
    end
    a_req = 0; b_req = 0;
    n = 0;
    while (busy && n < 40) begin step(); n++; end
    chk("rand_idle", 32'(n < 40), 1);
    chk("rvalid_vs_reads", rv_cnt - rv, rd_beats - rb);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
